// File: rtl/memory_stage_if.sv
// memory_stage_if: bundles the execute-side handshake, the data-bus request /
// response pair and the writeback bundle of the memory stage.
// The slave modport is the memory stage's own view; the master modport is the
// view of whatever surrounds it (execute, data memory, writeback).
interface memory_stage_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) ();
    // Execute -> memory stage
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_pc;
    logic [ILEN-1:0] ex_instr;
    logic [4:0]      ex_dst;
    logic [XLEN-1:0] ex_result;
    logic [XLEN-1:0] ex_store_data;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic [2:0]      ex_size;
    logic            ex_regwrite;

    // Data bus request / response
    logic            dreq_valid;
    logic [XLEN-1:0] dreq_addr;
    logic [1:0]      dreq_size;
    logic [7:0]      dreq_strobe;
    logic [XLEN-1:0] dreq_data;
    logic            dresp_data_ok;
    logic [XLEN-1:0] dresp_data;

    // Memory stage -> writeback
    logic            m_valid;
    logic [XLEN-1:0] m_pc;
    logic [ILEN-1:0] m_instr;
    logic [4:0]      m_dst;
    logic [XLEN-1:0] m_writedata;
    logic            m_regwrite;
    logic            m_misalign;

    modport slave (
        input  ex_valid, ex_pc, ex_instr, ex_dst, ex_result, ex_store_data,
        input  ex_mem_read, ex_mem_write, ex_size, ex_regwrite,
        output ex_ready,
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_data_ok, dresp_data,
        output m_valid, m_pc, m_instr, m_dst, m_writedata, m_regwrite, m_misalign
    );

    modport master (
        output ex_valid, ex_pc, ex_instr, ex_dst, ex_result, ex_store_data,
        output ex_mem_read, ex_mem_write, ex_size, ex_regwrite,
        input  ex_ready,
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_data_ok, dresp_data,
        input  m_valid, m_pc, m_instr, m_dst, m_writedata, m_regwrite, m_misalign
    );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: pipeline stage between execute and writeback. Holds one
// instruction at a time, issues its load/store on the data bus, aligns and
// extends load data, lane-shifts store data and presents a registered result
// bundle to writeback. Execute is stalled while a bus transaction is pending.
//
// Optional build macro: MEM_MISALIGN_CHECK_EN
//   defined   - misaligned loads/stores are not issued; they retire next cycle
//               with m_misalign=1 and no register write.
//   undefined - m_misalign stays 0 and every access is issued as is.
module memory_stage #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic          clk,
    input  logic          reset,      // asynchronous, active low
    memory_stage_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t          r_state;

    // Bundle latched at accept
    logic [XLEN-1:0] r_pc;
    logic [ILEN-1:0] r_instr;
    logic [4:0]      r_dst;
    logic [XLEN-1:0] r_addr;
    logic [2:0]      r_size;
    logic            r_regwrite;
    logic            r_is_load;

    // Bus request registers
    logic            r_dreq_valid;
    logic [7:0]      r_dreq_strobe;
    logic [XLEN-1:0] r_dreq_data;

    // Writeback bundle registers
    logic            r_m_valid;
    logic [XLEN-1:0] r_m_pc;
    logic [ILEN-1:0] r_m_instr;
    logic [4:0]      r_m_dst;
    logic [XLEN-1:0] r_m_writedata;
    logic            r_m_regwrite;
    logic            r_m_misalign;

    // Decode of the incoming bundle; a read+write combination behaves as a load
    logic            w_is_mem;
    logic            w_is_store;
    logic [2:0]      w_off;
    logic [3:0]      w_nbytes;
    logic [3:0]      w_lane_end;
    logic [7:0]      w_strobe;
    logic [XLEN-1:0] w_store_shifted;
    logic            w_misalign;

    // Load alignment from the latched address/size
    logic [XLEN-1:0] w_raw;
    logic [XLEN-1:0] w_load_data;

    assign w_is_mem        = bus.ex_mem_read | bus.ex_mem_write;
    assign w_is_store      = bus.ex_mem_write & ~bus.ex_mem_read;
    assign w_off           = bus.ex_result[2:0];
    assign w_nbytes        = 4'd1 << bus.ex_size[1:0];
    assign w_lane_end      = {1'b0, w_off} + w_nbytes;
    assign w_store_shifted = bus.ex_store_data << {w_off, 3'b000};

    // A byte lane is enabled when it lies in [off, off+size); lanes past 7
    // simply fall off, which matches a shifted-and-truncated mask.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_strobe
            assign w_strobe[gi] = w_is_store
                                  && (4'(gi) >= {1'b0, w_off})
                                  && (4'(gi) < w_lane_end);
        end
    endgenerate

`ifdef MEM_MISALIGN_CHECK_EN
    // Natural-alignment test of the incoming effective address
    always_comb begin
        w_misalign = 1'b0;
        case (bus.ex_size[1:0])
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = bus.ex_result[0];
            2'd2:    w_misalign = (bus.ex_result[1:0] != 2'b00);
            default: w_misalign = (bus.ex_result[2:0] != 3'b000);
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_raw = bus.dresp_data >> {r_addr[2:0], 3'b000};

    // Pick the accessed width from the aligned word and sign/zero extend it;
    // doubleword ignores the extension bit.
    always_comb begin
        w_load_data = w_raw;
        case (r_size[1:0])
            2'd0: w_load_data = r_size[2] ? {{(XLEN-8){1'b0}}, w_raw[7:0]}
                                          : {{(XLEN-8){w_raw[7]}}, w_raw[7:0]};
            2'd1: w_load_data = r_size[2] ? {{(XLEN-16){1'b0}}, w_raw[15:0]}
                                          : {{(XLEN-16){w_raw[15]}}, w_raw[15:0]};
            2'd2: w_load_data = r_size[2] ? {{(XLEN-32){1'b0}}, w_raw[31:0]}
                                          : {{(XLEN-32){w_raw[31]}}, w_raw[31:0]};
            default: w_load_data = w_raw;
        endcase
    end

    // Stage FSM: accept in IDLE, hold the bus request in REQ until completion,
    // and produce a one-cycle writeback pulse per instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_instr       <= '0;
            r_dst         <= '0;
            r_addr        <= '0;
            r_size        <= '0;
            r_regwrite    <= 1'b0;
            r_is_load     <= 1'b0;
            r_dreq_valid  <= 1'b0;
            r_dreq_strobe <= '0;
            r_dreq_data   <= '0;
            r_m_valid     <= 1'b0;
            r_m_pc        <= '0;
            r_m_instr     <= '0;
            r_m_dst       <= '0;
            r_m_writedata <= '0;
            r_m_regwrite  <= 1'b0;
            r_m_misalign  <= 1'b0;
        end else begin
            r_m_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.ex_valid) begin
                        r_pc          <= bus.ex_pc;
                        r_instr       <= bus.ex_instr;
                        r_dst         <= bus.ex_dst;
                        r_addr        <= bus.ex_result;
                        r_size        <= bus.ex_size;
                        r_regwrite    <= bus.ex_regwrite;
                        r_is_load     <= bus.ex_mem_read;
                        r_dreq_strobe <= w_strobe;
                        r_dreq_data   <= w_store_shifted;
                        if (w_is_mem && !w_misalign) begin
                            r_state      <= S_REQ;
                            r_dreq_valid <= 1'b1;
                        end else begin
                            // Non-memory op, or a memory op rejected as misaligned
                            r_m_valid     <= 1'b1;
                            r_m_pc        <= bus.ex_pc;
                            r_m_instr     <= bus.ex_instr;
                            r_m_dst       <= bus.ex_dst;
                            r_m_writedata <= w_is_mem ? '0 : bus.ex_result;
                            r_m_regwrite  <= w_is_mem ? 1'b0 : bus.ex_regwrite;
                            r_m_misalign  <= w_is_mem & w_misalign;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.dresp_data_ok) begin
                        r_state       <= S_IDLE;
                        r_dreq_valid  <= 1'b0;
                        r_m_valid     <= 1'b1;
                        r_m_pc        <= r_pc;
                        r_m_instr     <= r_instr;
                        r_m_dst       <= r_dst;
                        r_m_writedata <= r_is_load ? w_load_data : '0;
                        r_m_regwrite  <= r_is_load & r_regwrite;
                        r_m_misalign  <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_dreq_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ex_ready    = (r_state == S_IDLE);
    assign bus.dreq_valid  = r_dreq_valid;
    assign bus.dreq_addr   = r_addr;
    assign bus.dreq_size   = r_size[1:0];
    assign bus.dreq_strobe = r_dreq_strobe;
    assign bus.dreq_data   = r_dreq_data;

    assign bus.m_valid     = r_m_valid;
    assign bus.m_pc        = r_m_pc;
    assign bus.m_instr     = r_m_instr;
    assign bus.m_dst       = r_m_dst;
    assign bus.m_writedata = r_m_writedata;
    assign bus.m_regwrite  = r_m_regwrite;
`ifdef MEM_MISALIGN_CHECK_EN
    assign bus.m_misalign  = r_m_misalign;
`else
    assign bus.m_misalign  = 1'b0;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed test of memory_stage. Inputs change and outputs
// are sampled 1 ns after each rising clock edge.
module tb_memory_stage;
    localparam int XLEN = 64;
    localparam int ILEN = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    memory_stage_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

    memory_stage #(.XLEN(XLEN), .ILEN(ILEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ex();
        bus.ex_valid     = 1'b0;
        bus.ex_mem_read  = 1'b0;
        bus.ex_mem_write = 1'b0;
    endtask

    task automatic issue(input logic [63:0] pc, input logic [31:0] instr, input logic [4:0] dst,
                         input logic [63:0] result, input logic [63:0] sdata,
                         input logic rd, input logic wr, input logic [2:0] size,
                         input logic regwrite);
        bus.ex_valid      = 1'b1;
        bus.ex_pc         = pc;
        bus.ex_instr      = instr;
        bus.ex_dst        = dst;
        bus.ex_result     = result;
        bus.ex_store_data = sdata;
        bus.ex_mem_read   = rd;
        bus.ex_mem_write  = wr;
        bus.ex_size       = size;
        bus.ex_regwrite   = regwrite;
    endtask

    initial begin
        bus.ex_valid      = 1'b0;
        bus.ex_pc         = '0;
        bus.ex_instr      = '0;
        bus.ex_dst        = '0;
        bus.ex_result     = '0;
        bus.ex_store_data = '0;
        bus.ex_mem_read   = 1'b0;
        bus.ex_mem_write  = 1'b0;
        bus.ex_size       = '0;
        bus.ex_regwrite   = 1'b0;
        bus.dresp_data_ok = 1'b0;
        bus.dresp_data    = '0;

        // Reset state
        repeat (2) step();
        chk("reset_m_valid", 64'(bus.m_valid), 64'd0);
        chk("reset_dreq_valid", 64'(bus.dreq_valid), 64'd0);
        chk("reset_ex_ready", 64'(bus.ex_ready), 64'd1);
        chk("reset_m_writedata", bus.m_writedata, 64'd0);
        chk("reset_m_misalign", 64'(bus.m_misalign), 64'd0);
        reset = 1'b1;
        step();

        // Non-memory op: result one cycle after accept, single-cycle pulse
        issue(64'h100, 32'h0000_0013, 5'd5, 64'h1234, 64'h0, 1'b0, 1'b0, 3'd3, 1'b1);
        chk("t1_ex_ready", 64'(bus.ex_ready), 64'd1);
        step();
        idle_ex();
        chk("t1_m_valid", 64'(bus.m_valid), 64'd1);
        chk("t1_m_writedata", bus.m_writedata, 64'h1234);
        chk("t1_m_dst", 64'(bus.m_dst), 64'd5);
        chk("t1_m_regwrite", 64'(bus.m_regwrite), 64'd1);
        chk("t1_m_pc", bus.m_pc, 64'h100);
        chk("t1_dreq_valid", 64'(bus.dreq_valid), 64'd0);
        step();
        chk("t1_m_valid_pulse", 64'(bus.m_valid), 64'd0);

        // Load byte signed at 0x1003, completion in the third request cycle
        issue(64'h104, 32'h0031_8383, 5'd7, 64'h1003, 64'h0, 1'b1, 1'b0, 3'b000, 1'b1);
        step();
        idle_ex();
        chk("t2_dreq_strobe", 64'(bus.dreq_strobe), 64'h00);
        chk("t2_dreq_size", 64'(bus.dreq_size), 64'd0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t2_dreq_valid_%0d", k), 64'(bus.dreq_valid), 64'd1);
            chk($sformatf("t2_dreq_addr_%0d", k), bus.dreq_addr, 64'h1003);
            chk($sformatf("t2_ex_ready_%0d", k), 64'(bus.ex_ready), 64'd0);
            chk($sformatf("t2_m_valid_%0d", k), 64'(bus.m_valid), 64'd0);
            if (k == 2) begin
                bus.dresp_data_ok = 1'b1;
                bus.dresp_data    = 64'h0000_0000_8000_0000;
            end
            step();
        end
        bus.dresp_data_ok = 1'b0;
        chk("t2_m_valid", 64'(bus.m_valid), 64'd1);
        chk("t2_m_writedata", bus.m_writedata, 64'hFFFF_FFFF_FFFF_FF80);
        chk("t2_m_dst", 64'(bus.m_dst), 64'd7);
        chk("t2_m_regwrite", 64'(bus.m_regwrite), 64'd1);
        chk("t2_dreq_valid_after", 64'(bus.dreq_valid), 64'd0);
        chk("t2_ex_ready_after", 64'(bus.ex_ready), 64'd1);
        step();
        chk("t2_m_valid_pulse", 64'(bus.m_valid), 64'd0);

        // Stray completion while idle is ignored
        bus.dresp_data_ok = 1'b1;
        step();
        bus.dresp_data_ok = 1'b0;
        chk("idle_ok_m_valid", 64'(bus.m_valid), 64'd0);
        chk("idle_ok_dreq_valid", 64'(bus.dreq_valid), 64'd0);

        // Load word unsigned at 0x2004, completion in first request cycle
        issue(64'h108, 32'h0041_6403, 5'd8, 64'h2004, 64'h0, 1'b1, 1'b0, 3'b110, 1'b1);
        step();
        idle_ex();
        chk("t3_dreq_valid", 64'(bus.dreq_valid), 64'd1);
        chk("t3_dreq_size", 64'(bus.dreq_size), 64'd2);
        bus.dresp_data_ok = 1'b1;
        bus.dresp_data    = 64'hDEAD_BEEF_0000_0000;
        step();
        bus.dresp_data_ok = 1'b0;
        chk("t3_m_valid", 64'(bus.m_valid), 64'd1);
        chk("t3_m_writedata", bus.m_writedata, 64'h0000_0000_DEAD_BEEF);

        // Store halfword at 0x3006
        issue(64'h10C, 32'h00B1_9323, 5'd3, 64'h3006, 64'hABCD, 1'b0, 1'b1, 3'b001, 1'b1);
        step();
        idle_ex();
        chk("t4_dreq_valid", 64'(bus.dreq_valid), 64'd1);
        chk("t4_dreq_strobe", 64'(bus.dreq_strobe), 64'hC0);
        chk("t4_dreq_data", bus.dreq_data, 64'hABCD_0000_0000_0000);
        chk("t4_dreq_addr", bus.dreq_addr, 64'h3006);
        bus.dresp_data_ok = 1'b1;
        step();
        bus.dresp_data_ok = 1'b0;
        chk("t4_m_valid", 64'(bus.m_valid), 64'd1);
        chk("t4_m_regwrite", 64'(bus.m_regwrite), 64'd0);
        chk("t4_m_writedata", bus.m_writedata, 64'd0);

        // Read and write both set: behaves as signed halfword load, no strobes
        issue(64'h110, 32'h0061_1083, 5'd9, 64'h6006, 64'h5555, 1'b1, 1'b1, 3'b001, 1'b1);
        step();
        idle_ex();
        chk("t5_dreq_strobe", 64'(bus.dreq_strobe), 64'h00);
        bus.dresp_data_ok = 1'b1;
        bus.dresp_data    = 64'h9ABC_0000_0000_0000;
        step();
        bus.dresp_data_ok = 1'b0;
        chk("t5_m_writedata", bus.m_writedata, 64'hFFFF_FFFF_FFFF_9ABC);
        chk("t5_m_regwrite", 64'(bus.m_regwrite), 64'd1);

        // Doubleword load ignores the extension bit
        issue(64'h114, 32'h0001_3503, 5'd10, 64'h5000, 64'h0, 1'b1, 1'b0, 3'b111, 1'b1);
        step();
        idle_ex();
        bus.dresp_data_ok = 1'b1;
        bus.dresp_data    = 64'h0123_4567_89AB_CDEF;
        step();
        bus.dresp_data_ok = 1'b0;
        chk("t6_m_writedata", bus.m_writedata, 64'h0123_4567_89AB_CDEF);

        // Word load at 0x4002 (misaligned)
        issue(64'h118, 32'h0021_2583, 5'd11, 64'h4002, 64'h0, 1'b1, 1'b0, 3'b010, 1'b1);
        step();
        idle_ex();
`ifdef MEM_MISALIGN_CHECK_EN
        chk("t7_dreq_valid", 64'(bus.dreq_valid), 64'd0);
        chk("t7_m_valid", 64'(bus.m_valid), 64'd1);
        chk("t7_m_misalign", 64'(bus.m_misalign), 64'd1);
        chk("t7_m_regwrite", 64'(bus.m_regwrite), 64'd0);
        chk("t7_m_writedata", bus.m_writedata, 64'd0);
        step();
        chk("t7_m_valid_pulse", 64'(bus.m_valid), 64'd0);
`else
        chk("t7_dreq_valid", 64'(bus.dreq_valid), 64'd1);
        chk("t7_m_valid", 64'(bus.m_valid), 64'd0);
        bus.dresp_data_ok = 1'b1;
        bus.dresp_data    = 64'h0000_8765_4321_0000;
        step();
        bus.dresp_data_ok = 1'b0;
        chk("t7_m_valid_done", 64'(bus.m_valid), 64'd1);
        chk("t7_m_misalign", 64'(bus.m_misalign), 64'd0);
        chk("t7_m_writedata", bus.m_writedata, 64'hFFFF_FFFF_8765_4321);
`endif

        // Reset while a request is outstanding
        issue(64'h11C, 32'h0001_3603, 5'd12, 64'h7000, 64'h0, 1'b1, 1'b0, 3'b011, 1'b1);
        step();
        idle_ex();
        chk("t8_dreq_valid_before", 64'(bus.dreq_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("t8_dreq_valid_async", 64'(bus.dreq_valid), 64'd0);
        chk("t8_ex_ready_in_reset", 64'(bus.ex_ready), 64'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        chk("t8_ex_ready", 64'(bus.ex_ready), 64'd1);
        chk("t8_m_valid", 64'(bus.m_valid), 64'd0);
        step();
        chk("t8_m_valid_next", 64'(bus.m_valid), 64'd0);
        chk("t8_dreq_valid_next", 64'(bus.dreq_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline memory stage between execute and writeback.
- Registers one instruction at a time from execute and issues loads/stores on the data bus.
- Aligns and extends load data; shifts store data and generates byte strobes.
- Presents a registered result bundle to writeback and back-pressures execute while a bus transaction is outstanding.

Parameters:
- XLEN, 64, datapath and address width.
- ILEN, 32, raw instruction width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute bundle valid.
- ex_ready  out  1  stage can accept a bundle this cycle.
- ex_pc  in  XLEN  instruction PC.
- ex_instr  in  ILEN  raw instruction.
- ex_dst  in  5  destination register.
- ex_result  in  XLEN  ALU result; also the effective address for loads/stores.
- ex_store_data  in  XLEN  rs2 value for stores.
- ex_mem_read  in  1  instruction is a load.
- ex_mem_write  in  1  instruction is a store.
- ex_size  in  3  [1:0] 0=B, 1=H, 2=W, 3=D; [2]=1 means zero-extend.
- ex_regwrite  in  1  instruction writes rd.
- dreq_valid  out  1  bus request valid.
- dreq_addr  out  XLEN  request address (unaligned byte address).
- dreq_size  out  2  ex_size[1:0].
- dreq_strobe  out  8  byte write enables; 0 for loads.
- dreq_data  out  XLEN  lane-shifted store data.
- dresp_data_ok  in  1  response/completion strobe.
- dresp_data  in  XLEN  raw 64-bit aligned load word.
- m_valid  out  1  writeback bundle valid.
- m_pc  out  XLEN  PC to writeback.
- m_instr  out  ILEN  raw instruction to writeback.
- m_dst  out  5  destination register to writeback.
- m_writedata  out  XLEN  value to write to rd.
- m_regwrite  out  1  register-write enable to writeback.
- m_misalign  out  1  misaligned-access flag (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all m_* outputs 0; dreq_valid=0; internal registers 0.
- FSM states:
  - IDLE:
    - ex_ready=1.
    - Accept on ex_valid&&ex_ready; latch all ex_* fields.
    - Accepted op is a load or store: next state REQ, m_valid=0 next cycle.
    - Accepted op is neither: m_* loaded from latched fields with m_writedata=ex_result; m_valid=1 next cycle; stay IDLE.
    - No accept: m_valid=0 next cycle.
  - REQ:
    - ex_ready=0; dreq_valid=1.
    - dreq_addr/size/strobe/data held stable from the latched bundle until dresp_data_ok.
    - On dresp_data_ok: m_* loaded (load data for loads, 0 for stores); m_valid=1 next cycle; next state IDLE; dreq_valid=0 next cycle.
- Latency:
  - Non-memory op: m_valid exactly 1 cycle after accept.
  - Memory op: dreq_valid from cycle accept+1; m_valid the cycle after dresp_data_ok.
  - dresp_data_ok in the first REQ cycle gives 2-cycle total latency.
- m_valid is a single-cycle pulse per instruction; writeback never stalls.
- Store lanes, with off=addr[2:0]:
  - dreq_strobe = (B:0x01, H:0x03, W:0x0F, D:0xFF) << off, truncated to 8 bits.
  - dreq_data = ex_store_data << (8*off), truncated to XLEN.
- Load extraction:
  - raw = dresp_data >> (8*off).
  - Take low 8/16/32/64 bits per size.
  - Sign-extend when ex_size[2]=0; zero-extend when 1. Size D ignores bit 2.
- Stores force m_regwrite=0 and m_writedata=0.
- m_dst=0 passes through unchanged; zeroing the write is done downstream.
- dresp_data_ok while in IDLE is ignored.
- ex_mem_read and ex_mem_write both set: treated as a load, with strobe=0.
- Reset asserted in REQ: abandons the transaction immediately; dreq_valid drops asynchronously.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined:
  - A memory op is misaligned when addr is not a multiple of its size (H: addr[0]; W: addr[1:0]!=0; D: addr[2:0]!=0).
  - A misaligned op skips REQ (no dreq_valid).
  - m_valid=1 next cycle with m_misalign=1, m_regwrite=0, m_writedata=0.
- Undefined: m_misalign tied to 0; all accesses are issued as is.

Test Plan:
- Reset release, then non-memory op ex_result=0x1234, dst=5, regwrite=1 -> next cycle m_valid=1, m_writedata=0x1234, m_dst=5; following cycle m_valid=0.
- Load B signed addr=0x1003, dresp_data=0x0000_0000_8000_0000 returned 3 cycles after request -> dreq_valid held 3 cycles with addr stable; ex_ready=0 throughout; m_writedata=0xFFFF_FFFF_FFFF_FF80.
- Load W unsigned addr=0x2004, dresp_data=0xDEAD_BEEF_0000_0000 -> m_writedata=0x0000_0000_DEAD_BEEF.
- Store H addr=0x3006, store_data=0xABCD -> dreq_strobe=0xC0, dreq_data=0xABCD_0000_0000_0000; after data_ok m_regwrite=0.
- Assert reset while in REQ -> dreq_valid=0 immediately; after release ex_ready=1 and no m_valid pulse.
- With MEM_MISALIGN_CHECK_EN defined, load W at addr=0x4002 -> no dreq_valid; next cycle m_valid=1, m_misalign=1.
